axis_galapagos_mux_packetizer: RTL and testbench



---
 rtl/axis_galapagos_mux_packetizer.sv | 205 ++++++++++++++++++++
 tb/tb_axis_galapagos_mux_packetizer.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_galapagos_mux_packetizer.sv
// Round-robin N-channel AXI-Stream packet collector feeding a single Galapagos stream.
// Each granted packet is buffered whole, then emitted as GP_DATA_WIDTH beats with TKEEP/TLAST/TDEST.
module axis_galapagos_mux_packetizer #(
    parameter int NUM_CHANNELS       = 2,
    parameter int AXIS_DATA_WIDTH    = 64,
    parameter int AXIS_NUM_TRANSFERS = 3,
    parameter int GP_DATA_WIDTH      = 128
) (
    input  logic                                      i_clk,
    input  logic                                      i_reset,
    input  logic [7:0]                                i_core_TID,
    input  logic [8*NUM_CHANNELS-1:0]                 i_core_TDEST,
    input  logic [NUM_CHANNELS-1:0]                   i_axis_TVALID,
    output logic [NUM_CHANNELS-1:0]                   o_axis_TREADY,
    input  logic [AXIS_DATA_WIDTH*NUM_CHANNELS-1:0]   i_axis_TDATA,
    output logic                                      o_gp_TVALID,
    input  logic                                      i_gp_TREADY,
    output logic [GP_DATA_WIDTH-1:0]                  o_gp_TDATA,
    output logic [GP_DATA_WIDTH/8-1:0]                o_gp_TKEEP,
    output logic [7:0]                                o_gp_TDEST,
    output logic [7:0]                                o_gp_TID,
    output logic                                      o_gp_TLAST
);

    localparam int P     = AXIS_DATA_WIDTH * AXIS_NUM_TRANSFERS;
    localparam int NB    = (P + GP_DATA_WIDTH - 1) / GP_DATA_WIDTH;
    localparam int LB    = (P - (NB - 1) * GP_DATA_WIDTH) / 8;
    localparam int KW    = GP_DATA_WIDTH / 8;
    localparam int BUF_W = NB * GP_DATA_WIDTH;
    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int CNT_W = (AXIS_NUM_TRANSFERS > 1) ? $clog2(AXIS_NUM_TRANSFERS + 1) : 1;
    localparam int J_W   = (NB > 1) ? $clog2(NB + 1) : 1;

    localparam logic [KW-1:0]           FULL_KEEP = {KW{1'b1}};
    localparam logic [KW-1:0]           LAST_KEEP = FULL_KEEP >> (KW - LB);
    localparam logic [NUM_CHANNELS-1:0] GRANT_LSB = NUM_CHANNELS'(1'b1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    function automatic int lowest_set(input logic [NUM_CHANNELS-1:0] vec);
        int pos;
        pos = 0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                pos = i;
            end
        end
        return pos;
    endfunction

    state_t                     state_q, state_d;
    logic [CH_W-1:0]            rr_q, rr_d;
    logic [CH_W-1:0]            grant_q, grant_d;
    logic [CNT_W-1:0]           in_cnt_q, in_cnt_d;
    logic [J_W-1:0]             j_q, j_d;
    logic [BUF_W-1:0]           buf_q, buf_d;
    logic [NUM_CHANNELS-1:0]    tready_q, tready_d;
    logic                       tvalid_q, tvalid_d;
    logic [GP_DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic [KW-1:0]              tkeep_q, tkeep_d;
    logic                       tlast_q, tlast_d;
    logic [7:0]                 tdest_q, tdest_d;

    logic [2*NUM_CHANNELS-1:0]  tvalid_dbl_s;
    logic [NUM_CHANNELS-1:0]    tvalid_rot_s;
    int                         arb_off_s;
    int                         arb_sum_s;
    logic                       arb_valid_s;
    logic [CH_W-1:0]            arb_idx_s;
    logic [AXIS_DATA_WIDTH-1:0] beat_s;
    logic                       in_valid_s;
    logic [J_W-1:0]             next_j_s;

    assign beat_s     = i_axis_TDATA[grant_q*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
    assign in_valid_s = i_axis_TVALID[grant_q];
    assign next_j_s   = j_q + J_W'(1);

    // Round-robin scan: rotate valids so offset 0 is the channel at the pointer.
    always_comb begin
        tvalid_dbl_s = {i_axis_TVALID, i_axis_TVALID};
        tvalid_rot_s = NUM_CHANNELS'(tvalid_dbl_s >> rr_q);
        arb_off_s    = lowest_set(tvalid_rot_s);
        arb_sum_s    = int'(rr_q) + arb_off_s;
        arb_valid_s  = |i_axis_TVALID;
        arb_idx_s    = (arb_sum_s >= NUM_CHANNELS) ? CH_W'(arb_sum_s - NUM_CHANNELS)
                                                   : CH_W'(arb_sum_s);
    end

    // Next-state and output-register logic for the IDLE/COLLECT/EMIT sequence.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        grant_d  = grant_q;
        in_cnt_d = in_cnt_q;
        j_d      = j_q;
        buf_d    = buf_q;
        tready_d = tready_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        tdest_d  = tdest_q;

        case (state_q)
            S_IDLE: begin
                if (arb_valid_s) begin
                    grant_d  = arb_idx_s;
                    tdest_d  = i_core_TDEST[arb_idx_s*8 +: 8];
                    tready_d = GRANT_LSB << arb_idx_s;
                    in_cnt_d = {CNT_W{1'b0}};
                    state_d  = S_COLLECT;
                end else begin
                    tready_d = {NUM_CHANNELS{1'b0}};
                end
            end
            S_COLLECT: begin
                if (in_valid_s) begin
                    buf_d[in_cnt_q*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = beat_s;
                    if (in_cnt_q == CNT_W'(AXIS_NUM_TRANSFERS - 1)) begin
                        // First output beat must already include the beat accepted this cycle.
                        state_d  = S_EMIT;
                        tready_d = {NUM_CHANNELS{1'b0}};
                        j_d      = {J_W{1'b0}};
                        tvalid_d = 1'b1;
                        tdata_d  = buf_d[GP_DATA_WIDTH-1:0];
                        tkeep_d  = (NB == 1) ? LAST_KEEP : FULL_KEEP;
                        tlast_d  = (NB == 1) ? 1'b1 : 1'b0;
                    end else begin
                        in_cnt_d = in_cnt_q + CNT_W'(1);
                    end
                end else begin
                    in_cnt_d = in_cnt_q;
                end
            end
            S_EMIT: begin
                if (tvalid_q && i_gp_TREADY) begin
                    if (j_q == J_W'(NB - 1)) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        rr_d     = (grant_q == CH_W'(NUM_CHANNELS - 1)) ? {CH_W{1'b0}}
                                                                        : grant_q + CH_W'(1);
                        state_d  = S_IDLE;
                    end else begin
                        j_d     = next_j_s;
                        tdata_d = buf_q[next_j_s*GP_DATA_WIDTH +: GP_DATA_WIDTH];
                        tkeep_d = (next_j_s == J_W'(NB - 1)) ? LAST_KEEP : FULL_KEEP;
                        tlast_d = (next_j_s == J_W'(NB - 1)) ? 1'b1 : 1'b0;
                    end
                end else begin
                    tvalid_d = tvalid_q;
                end
            end
            default: begin
                state_d  = S_IDLE;
                tready_d = {NUM_CHANNELS{1'b0}};
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; synchronous reset drops any partial packet.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            rr_q     <= {CH_W{1'b0}};
            grant_q  <= {CH_W{1'b0}};
            in_cnt_q <= {CNT_W{1'b0}};
            j_q      <= {J_W{1'b0}};
            buf_q    <= {BUF_W{1'b0}};
            tready_q <= {NUM_CHANNELS{1'b0}};
            tvalid_q <= 1'b0;
            tdata_q  <= {GP_DATA_WIDTH{1'b0}};
            tkeep_q  <= {KW{1'b0}};
            tlast_q  <= 1'b0;
            tdest_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            in_cnt_q <= in_cnt_d;
            j_q      <= j_d;
            buf_q    <= buf_d;
            tready_q <= tready_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
            tdest_q  <= tdest_d;
        end
    end

    assign o_axis_TREADY = tready_q;
    assign o_gp_TVALID   = tvalid_q;
    assign o_gp_TDATA    = tdata_q;
    assign o_gp_TKEEP    = tkeep_q;
    assign o_gp_TLAST    = tlast_q;
    assign o_gp_TDEST    = tdest_q;
    assign o_gp_TID      = i_core_TID;

endmodule

// File: tb/tb_axis_galapagos_mux_packetizer.sv
// Randomized bench for the packetizer: a packet-level scoreboard predicts grants, beats, TKEEP and TLAST.
module tb_axis_galapagos_mux_packetizer;

    localparam int N  = 2;
    localparam int W  = 64;
    localparam int T  = 3;
    localparam int G  = 128;
    localparam int P  = W * T;
    localparam int NB = (P + G - 1) / G;
    localparam int LB = (P - (NB - 1) * G) / 8;
    localparam logic [15:0] LKEEP = 16'((32'd1 << LB) - 32'd1);

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   core_tid;
    logic [15:0]  core_tdest;
    logic [1:0]   axis_tvalid, axis_tready;
    logic [127:0] axis_tdata;
    logic         gp_tvalid, gp_tready, gp_tlast;
    logic [127:0] gp_tdata;
    logic [15:0]  gp_tkeep;
    logic [7:0]   gp_tdest, gp_tid;

    logic         rst2;
    logic [1:0]   tvalid2, tready2;
    logic [127:0] tdata2;
    logic         gp2_tvalid, gp2_tready, gp2_tlast;
    logic [191:0] gp2_tdata;
    logic [23:0]  gp2_tkeep;
    logic [7:0]   gp2_tdest, gp2_tid;

    always #5 clk = ~clk;

    axis_galapagos_mux_packetizer #(.NUM_CHANNELS(N), .AXIS_DATA_WIDTH(W),
        .AXIS_NUM_TRANSFERS(T), .GP_DATA_WIDTH(G)) dut (
        .i_clk(clk), .i_reset(rst), .i_core_TID(core_tid), .i_core_TDEST(core_tdest),
        .i_axis_TVALID(axis_tvalid), .o_axis_TREADY(axis_tready), .i_axis_TDATA(axis_tdata),
        .o_gp_TVALID(gp_tvalid), .i_gp_TREADY(gp_tready), .o_gp_TDATA(gp_tdata),
        .o_gp_TKEEP(gp_tkeep), .o_gp_TDEST(gp_tdest), .o_gp_TID(gp_tid), .o_gp_TLAST(gp_tlast));

    axis_galapagos_mux_packetizer #(.NUM_CHANNELS(2), .AXIS_DATA_WIDTH(64),
        .AXIS_NUM_TRANSFERS(3), .GP_DATA_WIDTH(192)) dut_fit (
        .i_clk(clk), .i_reset(rst2), .i_core_TID(core_tid), .i_core_TDEST(core_tdest),
        .i_axis_TVALID(tvalid2), .o_axis_TREADY(tready2), .i_axis_TDATA(tdata2),
        .o_gp_TVALID(gp2_tvalid), .i_gp_TREADY(gp2_tready), .o_gp_TDATA(gp2_tdata),
        .o_gp_TKEEP(gp2_tkeep), .o_gp_TDEST(gp2_tdest), .o_gp_TID(gp2_tid), .o_gp_TLAST(gp2_tlast));

    int checks = 0;
    int errors = 0;

    logic [63:0]  src[N][$];
    int           valid_pct[N];
    int           ready_pct;
    int           vscript[$];
    int           out_order[$];
    logic [127:0] obeats[$];

    // Packet-level reference state: 0 = waiting for a grant, 1 = collecting, 2 = emitting.
    int           phase, grant_m, rr_m, in_cnt, out_j;
    logic [7:0]   dest_m;
    logic [255:0] cur_pkt;
    logic [1:0]   hs_in;
    logic         after_reset;

    function automatic int scan_from(input int start, input logic [1:0] v);
        for (int off = 0; off < N; off++) begin
            if (v[(start + off) % N]) return (start + off) % N;
        end
        return 0;
    endfunction

    task automatic monitor();
        logic [1:0]   exp_rdy;
        logic [127:0] exp_data;
        logic [15:0]  exp_keep;
        logic         exp_last;
        hs_in = axis_tvalid & axis_tready;
        if (rst) begin
            phase = 0; rr_m = 0; in_cnt = 0; out_j = 0; cur_pkt = '0; hs_in = 2'b00;
            after_reset = 1'b1; out_order.delete(); obeats.delete();
            return;
        end
        checks++;
        if (gp_tid !== core_tid) begin
            errors++; $display("FAIL tid got %h exp %h", gp_tid, core_tid);
        end
        if (after_reset) begin
            after_reset = 1'b0;
            checks++;
            if ({axis_tready, gp_tvalid, gp_tlast, gp_tdata, gp_tkeep, gp_tdest} !== '0) begin
                errors++;
                $display("FAIL reset_state got rdy=%b v=%b l=%b d=%h k=%h dest=%h exp all zero",
                         axis_tready, gp_tvalid, gp_tlast, gp_tdata, gp_tkeep, gp_tdest);
            end
        end
        case (phase)
            0: begin
                checks++;
                if (axis_tready !== 2'b00 || gp_tvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_outputs got rdy=%b v=%b exp rdy=00 v=0", axis_tready, gp_tvalid);
                end
                if (|axis_tvalid) begin
                    grant_m = scan_from(rr_m, axis_tvalid);
                    dest_m  = core_tdest[grant_m*8 +: 8];
                    cur_pkt = '0;
                    in_cnt  = 0;
                    phase   = 1;
                end
            end
            1: begin
                exp_rdy = 2'(32'd1 << grant_m);
                checks++;
                if (axis_tready !== exp_rdy || gp_tvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL collect_ready got rdy=%b v=%b exp rdy=%b v=0", axis_tready, gp_tvalid, exp_rdy);
                end
                if (axis_tvalid[grant_m] && axis_tready[grant_m]) begin
                    cur_pkt[in_cnt*64 +: 64] = axis_tdata[grant_m*64 +: 64];
                    in_cnt++;
                    if (in_cnt == T) begin
                        phase = 2;
                        out_j = 0;
                    end
                end
            end
            default: begin
                exp_data = cur_pkt[out_j*128 +: 128];
                exp_keep = (out_j == NB - 1) ? LKEEP : 16'hFFFF;
                exp_last = (out_j == NB - 1);
                checks++;
                if (axis_tready !== 2'b00 || gp_tvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL emit_valid got rdy=%b v=%b exp rdy=00 v=1", axis_tready, gp_tvalid);
                end
                checks++;
                if (gp_tdata !== exp_data) begin
                    errors++; $display("FAIL emit_data beat %0d got %h exp %h", out_j, gp_tdata, exp_data);
                end
                checks++;
                if (gp_tkeep !== exp_keep || gp_tlast !== exp_last) begin
                    errors++;
                    $display("FAIL emit_keep_last beat %0d got k=%h l=%b exp k=%h l=%b",
                             out_j, gp_tkeep, gp_tlast, exp_keep, exp_last);
                end
                checks++;
                if (gp_tdest !== dest_m) begin
                    errors++; $display("FAIL emit_dest got %h exp %h", gp_tdest, dest_m);
                end
                if (gp_tvalid && gp_tready) begin
                    obeats.push_back(gp_tdata);
                    out_j++;
                    if (out_j == NB) begin
                        out_order.push_back(grant_m);
                        rr_m  = (grant_m + 1) % N;
                        phase = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic drive();
        for (int c = 0; c < N; c++) begin
            logic v;
            if (hs_in[c] && src[c].size() > 0) void'(src[c].pop_front());
            if (src[c].size() == 0) v = 1'b0;
            else if (c == 0 && vscript.size() > 0) v = (vscript.pop_front() != 0);
            else if (axis_tvalid[c] && !hs_in[c]) v = 1'b1;
            else v = (int'($urandom_range(99)) < valid_pct[c]);
            axis_tvalid[c] = v;
            axis_tdata[c*64 +: 64] = v ? src[c][0] : {$urandom, $urandom};
        end
        gp_tready = (int'($urandom_range(99)) < ready_pct);
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int c = 0; c < N; c++) src[c].delete();
        vscript.delete();
        step();
        rst = 1'b0;
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n;
        n = 0;
        while (!(src[0].size() == 0 && src[1].size() == 0 && phase == 0) && n < max_cycles) begin
            step();
            n++;
        end
        checks++;
        if (n >= max_cycles) begin
            errors++; $display("FAIL timeout got %0d cycles exp under %0d", n, max_cycles);
        end
    endtask

    task automatic push_pkt(input int c, input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2);
        src[c].push_back(d0);
        src[c].push_back(d1);
        src[c].push_back(d2);
    endtask

    task automatic push_rand(input int c);
        push_pkt(c, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    endtask

    task automatic check_order(input string name, input int exp_q[$]);
        checks++;
        if (out_order.size() != exp_q.size()) begin
            errors++; $display("FAIL %s_count got %0d exp %0d", name, out_order.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (out_order[i] != exp_q[i]) begin
                    errors++; $display("FAIL %s[%0d] got ch%0d exp ch%0d", name, i, out_order[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic check_two_beats(input string name, input int base, input logic [63:0] d0,
                                   input logic [63:0] d1, input logic [63:0] d2);
        checks++;
        if (obeats.size() < base + 2) begin
            errors++; $display("FAIL %s_beats got %0d exp %0d", name, obeats.size(), base + 2);
        end else begin
            checks++;
            if (obeats[base] !== {d1, d0} || obeats[base+1] !== {64'h0, d2}) begin
                errors++;
                $display("FAIL %s_data got %h %h exp %h %h", name, obeats[base], obeats[base+1],
                         {d1, d0}, {64'h0, d2});
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        step();
        checks++;
        if (gp_tvalid !== 1'b0 || axis_tready !== 2'b00 || gp_tkeep !== 16'h0000) begin
            errors++; $display("FAIL reset_idle got v=%b rdy=%b k=%h exp 0", gp_tvalid, axis_tready, gp_tkeep);
        end
    endtask

    task automatic test_single();
        do_reset();
        valid_pct[0] = 100; valid_pct[1] = 100; ready_pct = 100;
        push_pkt(0, 64'hA0, 64'hA1, 64'hA2);
        run_until_idle(40);
        check_two_beats("single", 0, 64'hA0, 64'hA1, 64'hA2);
        check_order("single_order", '{0});
    endtask

    task automatic test_round_robin();
        do_reset();
        valid_pct[0] = 100; valid_pct[1] = 100; ready_pct = 100;
        for (int k = 0; k < 3; k++) begin
            push_rand(0);
            push_rand(1);
        end
        run_until_idle(200);
        check_order("rr_order", '{0, 1, 0, 1, 0, 1});
    endtask

    task automatic test_backpressure();
        logic [63:0]  d0, d1, d2;
        logic [127:0] sd;
        logic [15:0]  sk;
        logic         sl;
        int           n;
        do_reset();
        d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom}; d2 = {$urandom, $urandom};
        valid_pct[0] = 100; ready_pct = 0;
        push_pkt(0, d0, d1, d2);
        n = 0;
        while (!gp_tvalid && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (!gp_tvalid) begin
            errors++; $display("FAIL bp_valid_rise got 0 exp 1");
        end
        sd = gp_tdata; sk = gp_tkeep; sl = gp_tlast;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (gp_tvalid !== 1'b1 || gp_tdata !== sd || gp_tkeep !== sk || gp_tlast !== sl) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got v=%b d=%h k=%h l=%b exp v=1 d=%h k=%h l=%b",
                         i, gp_tvalid, gp_tdata, gp_tkeep, gp_tlast, sd, sk, sl);
            end
        end
        ready_pct = 100;
        run_until_idle(40);
        checks++;
        if (obeats.size() != 2) begin
            errors++; $display("FAIL bp_beat_count got %0d exp 2", obeats.size());
        end
        check_two_beats("bp", 0, d0, d1, d2);
    endtask

    task automatic test_gaps();
        logic [63:0] d0, d1, d2;
        do_reset();
        d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom}; d2 = {$urandom, $urandom};
        valid_pct[0] = 100; valid_pct[1] = 100; ready_pct = 100;
        push_pkt(0, d0, d1, d2);
        push_rand(1);
        vscript = '{1, 0, 0, 1, 0, 1};
        run_until_idle(80);
        check_two_beats("gaps", 0, d0, d1, d2);
        check_order("gaps_order", '{0, 1});
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        valid_pct[0] = 100; valid_pct[1] = 100; ready_pct = 100;
        push_rand(0);
        run_until_idle(40);
        push_pkt(1, 64'hDEAD_0000, 64'hDEAD_0001, 64'hDEAD_0002);
        n = 0;
        while (!(phase == 1 && in_cnt == 2) && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (!(phase == 1 && in_cnt == 2)) begin
            errors++; $display("FAIL rstmid_partial got in_cnt %0d exp 2", in_cnt);
        end
        do_reset();
        step();
        push_pkt(1, 64'hB0, 64'hB1, 64'hB2);
        push_pkt(0, 64'hC0, 64'hC1, 64'hC2);
        run_until_idle(80);
        check_order("rstmid_order", '{0, 1});
        check_two_beats("rstmid_ch0", 0, 64'hC0, 64'hC1, 64'hC2);
        check_two_beats("rstmid_ch1", 2, 64'hB0, 64'hB1, 64'hB2);
    endtask

    task automatic test_random();
        int cnt0, cnt1;
        do_reset();
        core_tdest = {8'($urandom_range(128, 255)), 8'($urandom_range(0, 127))};
        core_tid   = 8'($urandom);
        for (int r = 0; r < 3; r++) begin
            valid_pct[0] = int'($urandom_range(30, 100));
            valid_pct[1] = int'($urandom_range(30, 100));
            ready_pct    = int'($urandom_range(30, 100));
            for (int k = 0; k < 4; k++) begin
                push_rand(0);
                push_rand(1);
            end
            run_until_idle(2000);
        end
        cnt0 = 0; cnt1 = 0;
        foreach (out_order[i]) begin
            if (out_order[i] == 0) cnt0++;
            else cnt1++;
        end
        checks++;
        if (cnt0 != 12 || cnt1 != 12) begin
            errors++; $display("FAIL random_counts got %0d/%0d exp 12/12", cnt0, cnt1);
        end
    endtask

    task automatic test_exact_fit();
        logic [63:0] d[3];
        int n;
        d[0] = 64'hA0; d[1] = 64'hA1; d[2] = 64'hA2;
        rst2 = 1'b1; tvalid2 = 2'b00; tdata2 = '0; gp2_tready = 1'b1;
        @(posedge clk); #1;
        rst2 = 1'b0;
        @(negedge clk);
        checks++;
        if (gp2_tvalid !== 1'b0 || gp2_tkeep !== 24'h0 || gp2_tdata !== '0) begin
            errors++; $display("FAIL fit_reset got v=%b k=%h exp 0", gp2_tvalid, gp2_tkeep);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            tvalid2 = 2'b01;
            tdata2  = {64'h0, d[k]};
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!tready2[0] && n < 20);
            checks++;
            if (!tready2[0]) begin
                errors++; $display("FAIL fit_input_beat%0d got no ready exp ready", k);
            end
            @(posedge clk); #1;
        end
        tvalid2 = 2'b00;
        @(negedge clk);
        checks++;
        if (gp2_tvalid !== 1'b1 || gp2_tdata !== {64'hA2, 64'hA1, 64'hA0}) begin
            errors++; $display("FAIL fit_data got v=%b d=%h exp v=1 d=%h", gp2_tvalid, gp2_tdata,
                               {64'hA2, 64'hA1, 64'hA0});
        end
        checks++;
        if (gp2_tkeep !== 24'hFFFFFF || gp2_tlast !== 1'b1 || gp2_tdest !== core_tdest[7:0]) begin
            errors++; $display("FAIL fit_keep_last got k=%h l=%b dest=%h exp k=ffffff l=1 dest=%h",
                               gp2_tkeep, gp2_tlast, gp2_tdest, core_tdest[7:0]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (gp2_tvalid !== 1'b0) begin
            errors++; $display("FAIL fit_valid_drop got %b exp 0", gp2_tvalid);
        end
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        core_tid = 8'h3C; core_tdest = {8'h02, 8'h01};
        axis_tvalid = 2'b00; axis_tdata = '0; gp_tready = 1'b0;
        tvalid2 = 2'b00; tdata2 = '0; gp2_tready = 1'b0;
        valid_pct[0] = 100; valid_pct[1] = 100; ready_pct = 100;
        phase = 0; rr_m = 0; in_cnt = 0; out_j = 0; grant_m = 0; dest_m = 8'h00;
        cur_pkt = '0; hs_in = 2'b00; after_reset = 1'b0;
        step();
        test_reset();
        core_tdest = {8'h02, 8'h05};
        test_single();
        core_tdest = {8'h02, 8'h01};
        test_round_robin();
        test_backpressure();
        test_gaps();
        test_reset_mid();
        test_random();
        test_exact_fit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
